// File: rtl/pad_attr_pkg.sv
// Shared types and constants for the pad attribute configuration transmitter.
package pad_attr_pkg;

  // Transmitter frame states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StShift  = 2'd2,
    StUpdate = 2'd3
  } pad_attr_tx_state_e;

  // Native attribute word width of the pad attribute chain.
  localparam int unsigned PadAttrDw = 32;

  // All attribute bits writable by default.
  localparam logic [PadAttrDw-1:0] PadAttrMaskDefault = '1;

endpackage : pad_attr_pkg

// File: rtl/pad_attr_cfg_tx.sv
// Pad attribute configuration transmitter: collects one masked attribute word per pad,
// then shifts the whole frame out MSB-first (highest pad first) and pulses an update strobe.
module pad_attr_cfg_tx
  import pad_attr_pkg::*;
#(
  parameter int unsigned        NumPads  = 4,
  parameter int unsigned        AttrDw   = PadAttrDw,
  parameter logic [AttrDw-1:0]  AttrMask = AttrDw'(PadAttrMaskDefault)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [AttrDw-1:0] cfg_attr_i,
  input  logic              abort_i,
  output logic              scan_en_o,
  output logic              scan_data_o,
  output logic              scan_update_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned TotalBits = NumPads * AttrDw;
  localparam int unsigned CntW      = $clog2(TotalBits + 1);
  localparam int unsigned IdxW      = (NumPads > 1) ? $clog2(NumPads) : 1;

  pad_attr_tx_state_e state_q, state_d;

  logic [IdxW-1:0]      word_idx_q, word_idx_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [TotalBits-1:0] shreg_q, shreg_d;
  logic [TotalBits-1:0] load_vec;
  logic [AttrDw-1:0]    attr_buf_q [NumPads];

  logic [AttrDw-1:0] attr_masked;
  logic              accept;
  logic              last_word;
  logic              shift_done;

  assign attr_masked = cfg_attr_i & AttrMask;
  // Ready is decoded from registered state only, so accept has no output feedback.
  assign accept      = cfg_valid_i & ((state_q == StIdle) | (state_q == StLoad));
  assign last_word   = (word_idx_q == IdxW'(NumPads - 1));
  assign shift_done  = (state_q == StShift) & (bit_cnt_q == CntW'(1));

  // Frame image for the shift register: pad p occupies bits [p*AttrDw +: AttrDw], so the
  // highest pad leaves first. The last pad comes straight from the input being accepted.
  always_comb begin
    load_vec = '0;
    for (int p = 0; p < int'(NumPads); p++) begin
      if (p == int'(NumPads) - 1) begin
        load_vec[p*AttrDw +: AttrDw] = attr_masked;
      end else begin
        load_vec[p*AttrDw +: AttrDw] = attr_buf_q[p];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StLoad: begin
          if (accept) begin
            state_d = last_word ? StShift : StLoad;
          end
        end
        StShift: begin
          if (shift_done) begin
            state_d = StUpdate;
          end
        end
        StUpdate: state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // FSM outputs, decoded from registered state and the shift register only.
  always_comb begin
    cfg_ready_o   = 1'b0;
    scan_en_o     = 1'b0;
    scan_data_o   = 1'b0;
    scan_update_o = 1'b0;
    done_o        = 1'b0;
    busy_o        = (state_q != StIdle);
    unique case (state_q)
      StIdle, StLoad: cfg_ready_o = 1'b1;
      StShift: begin
        scan_en_o   = 1'b1;
        scan_data_o = shreg_q[TotalBits-1];
      end
      StUpdate: begin
        scan_update_o = 1'b1;
        done_o        = 1'b1;
      end
      default: ;
    endcase
  end

  // Counter and shift register next-state; abort clears counters but keeps the shifter image.
  always_comb begin
    word_idx_d = word_idx_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    if (abort_i) begin
      word_idx_d = '0;
      bit_cnt_d  = '0;
    end else if (accept) begin
      if (last_word) begin
        word_idx_d = '0;
        bit_cnt_d  = CntW'(TotalBits);
        shreg_d    = load_vec;
      end else begin
        word_idx_d = word_idx_q + IdxW'(1);
      end
    end else if (state_q == StShift) begin
      shreg_d = shreg_q << 1;
      if (bit_cnt_q != '0) begin
        bit_cnt_d = bit_cnt_q - CntW'(1);
      end
    end
  end

  // Counter and shift register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_idx_q <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
    end else begin
      word_idx_q <= word_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
    end
  end

  // Frame buffer: masked words stored per pad; an abort in the same cycle drops the write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < int'(NumPads); p++) begin
        attr_buf_q[p] <= '0;
      end
    end else if (accept && !abort_i) begin
      attr_buf_q[word_idx_q] <= attr_masked;
    end
  end

endmodule : pad_attr_cfg_tx

// File: tb/tb_pad_attr_cfg_tx.sv
// Directed bench for pad_attr_cfg_tx with two pads of 4-bit attributes.
// Instance a uses a full mask, instance b masks with 4'h5.
module tb_pad_attr_cfg_tx;

  logic clk;
  logic rst_n;

  logic       valid_a, abort_a;
  logic [3:0] attr_a;
  logic       ready_a, en_a, data_a, upd_a, busy_a, done_a;

  logic       valid_b, abort_b;
  logic [3:0] attr_b;
  logic       ready_b, en_b, data_b, upd_b, busy_b, done_b;

  int n_cmp;
  int n_bad;

  pad_attr_cfg_tx #(
    .NumPads (2),
    .AttrDw  (4),
    .AttrMask(4'hF)
  ) u_dut_a (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_valid_i  (valid_a),
    .cfg_ready_o  (ready_a),
    .cfg_attr_i   (attr_a),
    .abort_i      (abort_a),
    .scan_en_o    (en_a),
    .scan_data_o  (data_a),
    .scan_update_o(upd_a),
    .busy_o       (busy_a),
    .done_o       (done_a)
  );

  pad_attr_cfg_tx #(
    .NumPads (2),
    .AttrDw  (4),
    .AttrMask(4'h5)
  ) u_dut_b (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_valid_i  (valid_b),
    .cfg_ready_o  (ready_b),
    .cfg_attr_i   (attr_b),
    .abort_i      (abort_b),
    .scan_en_o    (en_b),
    .scan_data_o  (data_b),
    .scan_update_o(upd_b),
    .busy_o       (busy_b),
    .done_o       (done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output bundle {ready, en, data, upd, done, busy} of the selected instance.
  function automatic logic [5:0] outs(input bit use_b);
    if (use_b) return {ready_b, en_b, data_b, upd_b, done_b, busy_b};
    return {ready_a, en_a, data_a, upd_a, done_a, busy_a};
  endfunction

  task automatic drive(input bit use_b, input logic v, input logic [3:0] w);
    if (use_b) begin
      valid_b = v;
      attr_b  = w;
    end else begin
      valid_a = v;
      attr_a  = w;
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle t+1 (first shift cycle), valid low.
  task automatic send_two(input bit use_b, input logic [3:0] w0, input logic [3:0] w1);
    drive(use_b, 1'b1, w0);
    @(negedge clk);
    drive(use_b, 1'b1, w1);
    @(negedge clk);
    drive(use_b, 1'b0, 4'h0);
  endtask

  // Called at the first shift cycle; checks 8 bits, the update cycle and ready return.
  task automatic stream(input bit use_b, input logic [7:0] exp, input string tag);
    logic [5:0] o;
    for (int i = 0; i < 8; i++) begin
      o = outs(use_b);
      chk({tag, "_en"}, 8'(o[4]), 8'd1);
      chk({tag, "_data"}, 8'(o[3]), 8'(exp[7-i]));
      chk({tag, "_rdy_low"}, 8'(o[5]), 8'd0);
      chk({tag, "_no_upd"}, 8'(o[2]), 8'd0);
      @(negedge clk);
    end
    o = outs(use_b);
    chk({tag, "_upd"}, 8'(o[2]), 8'd1);
    chk({tag, "_done"}, 8'(o[1]), 8'd1);
    chk({tag, "_en_off"}, 8'(o[4]), 8'd0);
    chk({tag, "_busy_upd"}, 8'(o[0]), 8'd1);
    @(negedge clk);
    o = outs(use_b);
    chk({tag, "_rdy_back"}, 8'(o[5]), 8'd1);
    chk({tag, "_upd_once"}, 8'(o[2]), 8'd0);
    chk({tag, "_done_once"}, 8'(o[1]), 8'd0);
  endtask

  initial begin
    logic upd_seen;
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    valid_a = 1'b0;
    attr_a  = 4'h0;
    abort_a = 1'b0;
    valid_b = 1'b0;
    attr_b  = 4'h0;
    abort_b = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    chk("rst_outs_a", 8'(outs(1'b0)), 8'b10_0000);
    chk("rst_outs_b", 8'(outs(1'b1)), 8'b10_0000);

    // 1: A then 3 -> pad1=3 first, then pad0=A.
    send_two(1'b0, 4'hA, 4'h3);
    stream(1'b0, 8'b0011_1010, "t1");

    // 2: mask 5 on instance b.
    send_two(1'b1, 4'hF, 4'hF);
    stream(1'b1, 8'b0101_0101, "t2");

    // 3: valid held through SHIFT with 7 waiting; it becomes pad 0 of the next frame.
    drive(1'b0, 1'b1, 4'h5);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h6);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h7);
    stream(1'b0, 8'b0110_0101, "t3a");
    @(negedge clk);
    chk("t3_load_busy", 8'(busy_a), 8'd1);
    chk("t3_load_rdy", 8'(ready_a), 8'd1);
    chk("t3_load_en", 8'(en_a), 8'd0);
    drive(1'b0, 1'b1, 4'h9);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0);
    stream(1'b0, 8'b1001_0111, "t3b");

    // 4: abort in shift cycle 3.
    send_two(1'b0, 4'h1, 4'h2);
    chk("t4_d1", 8'(data_a), 8'd0);
    @(negedge clk);
    chk("t4_d2", 8'(data_a), 8'd0);
    @(negedge clk);
    chk("t4_d3", 8'(data_a), 8'd1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("t4_en_drop", 8'(en_a), 8'd0);
    chk("t4_idle_busy", 8'(busy_a), 8'd0);
    chk("t4_idle_rdy", 8'(ready_a), 8'd1);
    upd_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      upd_seen = upd_seen | upd_a | done_a | en_a;
      @(negedge clk);
    end
    chk("t4_no_upd", 8'(upd_seen), 8'd0);
    send_two(1'b0, 4'hC, 4'h5);
    stream(1'b0, 8'b0101_1100, "t4");

    // 5: asynchronous reset mid-shift.
    send_two(1'b0, 4'h4, 4'h8);
    chk("t5_d1", 8'(data_a), 8'd1);
    @(negedge clk);
    chk("t5_d2", 8'(data_a), 8'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_outs", 8'(outs(1'b0)), 8'b10_0000);
    @(negedge clk);
    rst_n = 1'b1;
    upd_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      upd_seen = upd_seen | upd_a | done_a | en_a;
      @(negedge clk);
    end
    chk("t5_no_upd", 8'(upd_seen), 8'd0);
    chk("t5_rdy", 8'(ready_a), 8'd1);

    // 6: abort together with the last-word accept.
    drive(1'b0, 1'b1, 4'h1);
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h2);
    abort_a = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0);
    abort_a = 1'b0;
    chk("t6_outs", 8'(outs(1'b0)), 8'b10_0000);
    @(negedge clk);
    chk("t6_still_idle", 8'(outs(1'b0)), 8'b10_0000);
    send_two(1'b0, 4'hD, 4'hE);
    stream(1'b0, 8'b1110_1101, "t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pad_attr_cfg_tx
